// File: rtl/step_counter_pkg.sv
// Shared types and constants for the step counter: FSM state encoding and
// the width of one increment slice.
package step_counter_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/inc2_slice.sv
// One 2-bit increment slice; chained through ci/co to build a wider incrementer.
module inc2_slice
  import step_counter_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  assign {co, s} = {1'b0, a} + {{SLICE_W{1'b0}}, ci};

endmodule

// File: rtl/step_counter.sv
// Registered step counter around a chain of inc2_slice incrementers, with a
// start/len handshake bounding each run. Define STEP_COUNTER_SATURATE_EN to
// hold count at all-ones instead of wrapping.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] len,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NSLICE = WIDTH / SLICE_W;

  state_t           state, state_nx;
  logic [WIDTH-1:0] rem, rem_nx;
  logic [WIDTH-1:0] count_nx, sum;
  logic             ovf_nx;
  logic [NSLICE:0]  carry;
  logic             step;

  // Slice 0 carry-in tied high turns the adder chain into an incrementer.
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    inc2_slice u_slice (
      .a  (count[i*SLICE_W +: SLICE_W]),
      .ci (carry[i]),
      .s  (sum[i*SLICE_W +: SLICE_W]),
      .co (carry[i+1])
    );
  end

  assign step = (state == RUN) && en;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            rem_nx   = len;
            state_nx = RUN;
          end else begin
            state_nx = DONE;
          end
        end
      end
      RUN: begin
        if (en) begin
          rem_nx = rem - WIDTH'(1);
          if (rem == WIDTH'(1)) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // clr wins over the increment but leaves the step bookkeeping above untouched.
  always_comb begin
    count_nx = count;
    ovf_nx   = 1'b0;
    if (step) begin
      ovf_nx = carry[NSLICE];
`ifdef STEP_COUNTER_SATURATE_EN
      count_nx = carry[NSLICE] ? count : sum;
`else
      count_nx = sum;
`endif
    end
    if (clr) begin
      count_nx = '0;
      ovf_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
      count <= count_nx;
      ovf   <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter (WIDTH=2): directed literal checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_step_counter;

  localparam int W    = 2;
  localparam int MAXV = (1 << W) - 1;
`ifdef STEP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] len = '0;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] count;
  logic         ovf, busy, done;

  int testsRun = 0;
  int testsFailed = 0;
  bit cmpOn = 1'b0;

  // Model: run progress as "steps left", plus output flags.
  int m_count = 0;
  int m_left = 0;
  bit m_ovf = 1'b0;
  bit m_active = 1'b0;
  bit m_done = 1'b0;
  bit pa, pd;
  int c0;

  step_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .len   (len),
    .en    (en),
    .clr   (clr),
    .count (count),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input int l, input bit e, input bit c);
    rst_n = r;
    start = s;
    len   = W'(l);
    en    = e;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    pa = m_active;
    pd = m_done;
    if (!rst_n) begin
      m_count = 0; m_left = 0; m_ovf = 0; m_active = 0; m_done = 0;
    end else begin
      m_ovf  = 0;
      m_done = 0;
      if (pa && en) begin
        if (m_count == MAXV) begin
          m_ovf   = 1;
          m_count = SAT ? MAXV : 0;
        end else begin
          m_count = m_count + 1;
        end
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_active = 0;
          m_done   = 1;
        end
      end else if (!pa && !pd && start) begin
        if (int'(len) != 0) begin
          m_active = 1;
          m_left   = int'(len);
        end else begin
          m_done = 1;
        end
      end
      if (clr) begin
        m_count = 0;
        m_ovf   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("cyc_count", int'(count), m_count);
      checkOutput("cyc_ovf", int'(ovf), int'(m_ovf));
      checkOutput("cyc_busy", int'(busy), int'(m_active || m_done));
      checkOutput("cyc_done", int'(done), int'(m_done));
    end
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    cmpOn = 1'b1;
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_ovf", int'(ovf), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);

    // len=3 from 0 with en held
    applyStimulus(1, 1, 3, 1, 0);
    checkOutput("l3_busy_t1", int'(busy), 1);
    checkOutput("l3_count_t1", int'(count), 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("l3_count_t2", int'(count), 1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("l3_count_t3", int'(count), 2);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("l3_count_t4", int'(count), 3);
    checkOutput("l3_done_t4", int'(done), 1);
    checkOutput("l3_ovf_t4", int'(ovf), 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("l3_busy_t5", int'(busy), 0);
    checkOutput("l3_done_t5", int'(done), 0);

    // wrap (or saturate) from all-ones with len=1
    c0 = SAT ? 3 : 0;
    applyStimulus(1, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("wrap_count", int'(count), c0);
    checkOutput("wrap_ovf", int'(ovf), 1);
    checkOutput("wrap_done", int'(done), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("wrap_ovf_clear", int'(ovf), 0);

    // len=0 completes at t+1, restart accepted at t+2
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("l0_done", int'(done), 1);
    checkOutput("l0_count", int'(count), c0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("l0_done_t2", int'(done), 0);
    applyStimulus(1, 1, 2, 0, 0);
    checkOutput("l0_restart_busy", int'(busy), 1);

    // en pattern 1,0,0,1 with a start pulse ignored during RUN
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("gap_count1", int'(count), SAT ? 3 : 1);
    applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("gap_hold_done", int'(done), 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("gap_done", int'(done), 1);
    checkOutput("gap_count2", int'(count), SAT ? 3 : 2);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("gap_no_queue", int'(busy), 0);

    // clr mid-run at count=2
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("clr_idle", int'(count), 0);
    applyStimulus(1, 1, 3, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("clr_pre", int'(count), 2);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("clr_count", int'(count), 0);
    checkOutput("clr_done", int'(done), 1);

    // reset mid-run
    applyStimulus(1, 1, 3, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("mrst_count", int'(count), 0);
    checkOutput("mrst_busy", int'(busy), 0);
    checkOutput("mrst_done", int'(done), 0);
    repeat (4) applyStimulus(1, 0, 0, 1, 0);
    checkOutput("mrst_no_late_done", int'(done), 0);
    checkOutput("mrst_idle", int'(busy), 0);

    repeat (3000)
      applyStimulus(($urandom % 64) != 0, ($urandom % 3) == 0, int'($urandom % 4),
                    ($urandom % 4) != 0, ($urandom % 8) == 0);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/step_counter.md
# step_counter

Registered step counter that holds the running value feeding the 2-bit increment stage and captures its sum and carry each step. It is built as a chain of 2-bit increment slices. A start/length handshake bounds each run. It sits directly around the incrementer datapath: it supplies the operand, registers the result, and exports the carry as an overflow pulse to downstream control.

## Interface
- `WIDTH`, default 2: counter width in bits; must be even and ≥2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  request a run; sampled only in IDLE.
- `len`  in  WIDTH  number of increments for the run; sampled with `start`.
- `en`  in  1  step enable; an increment occurs only in RUN with `en`=1.
- `clr`  in  1  synchronous clear of `count`; accepted in any state.
- `count`  out  WIDTH  registered counter value.
- `ovf`  out  1  one-cycle pulse; the previous increment produced a carry out.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; run complete.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 and `len`≠0: load `rem`←`len`, go to RUN.
  - `start`=1 and `len`=0: go to DONE with no increments.
  - Otherwise stay in IDLE.
- **RUN**, each cycle with `en`=1:
  - `count`←`count`+1 (mod 2^WIDTH).
  - `rem`←`rem`−1.
  - If `rem`=1 before the decrement, go to DONE.
  - `en`=0 holds all state.
- **DONE**: `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE; no queuing.
- `clr`:
  - `count`←0 and `ovf`←0 that cycle.
  - Overrides any increment in the same cycle, but the step is still consumed (`rem` decrements).
  - Does not alter state.
- Arithmetic: the carry out of the top slice equals `count`=all-ones at the increment. `ovf` is registered from that carry.
- `rem` is internal, WIDTH bits, and never wraps: the exit is taken at `rem`=1.

## Timing
- Reset values: `count`=0, `ovf`=0, `busy`=0, `done`=0, state IDLE, `rem`=0.
- Reset mid-run aborts immediately. No `done` is issued.
- Latency from a `start` accepted at cycle t:
  - RUN begins at t+1.
  - With continuous `en`, the N-th increment lands at t+N.
  - `done`=1 at t+N+1.
  - IDLE, and `start` accepted again, at t+N+2.
- `len`=0: `done`=1 at t+1.
- Increment result is visible on `count` the cycle after the `en` edge. `ovf` is aligned with the wrapped `count`.
- `busy` is registered: rises at t+1, falls when IDLE is re-entered.
- `clr` and a wrapping increment in the same cycle: `count`=0, `ovf`=0.

## Configuration
- `STEP_COUNTER_SATURATE_EN` defined:
  - An increment at all-ones leaves `count` at all-ones.
  - `ovf` still pulses and the step is still consumed.
- Undefined: `count` wraps to 0 and `ovf` pulses.

## Structure
- `step_counter_pkg`:
  - state typedef with encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - `SLICE_W`=2 constant.
- Sub-module `inc2_slice`:
  - Inputs: 2-bit operand and carry-in.
  - Outputs: 2-bit sum and carry-out.
  - WIDTH/2 instances are chained. Slice 0 carry-in is tied to 1 for increment.

## Test plan
- WIDTH=2, `count`=0, `start` with `len`=3, `en`=1 held → `count` 1,2,3 at t+2..t+4; `done` at t+4; `busy` t+1..t+4; `ovf` never asserted.
- `count`=3, run `len`=1 → `count`=0 and `ovf`=1 for one cycle. With `STEP_COUNTER_SATURATE_EN`, `count` stays 3 and `ovf`=1.
- `start` with `len`=0 → `done` at t+1; `count` unchanged; second `start` at t+2 accepted.
- `len`=2 with `en` pattern 1,0,0,1 → `count` advances only on the two enabled cycles; `done` one cycle after the second. A `start` pulsed during RUN is ignored.
- `clr` asserted mid-run at `count`=2 with `en`=1 → `count`=0 next cycle; the run still ends after the original `len` steps.
- `rst_n`=0 for one cycle mid-run → next cycle `count`=0, `busy`=0, `done`=0, IDLE; no late `done`.
